// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces the
// first pressed row in the driven column and emits one value/valid strobe per press.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DEBOUNCE = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] value,
   output logic       valid,
   output logic       held
);

   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

   state_t          state, state_nxt;
   logic [3:0]      sync1, srows;
   logic [DW-1:0]   dwell;
   logic [1:0]      cidx, cidx_nxt;
   logic [1:0]      ridx, ridx_nxt;
   logic [CW-1:0]   db, db_nxt, db_inc;
   logic [3:0]      value_nxt, cols_nxt;
   logic            valid_nxt, held_nxt;
   logic            check_c, db_done_c, row_up_c;
   logic [1:0]      low_idx_c;

   assign check_c   = (dwell == DW'(SCAN_DIV - 1));
   assign row_up_c  = srows[ridx];
   assign db_inc    = (db == CW'(DEBOUNCE)) ? db : db + CW'(1);
   assign db_done_c = (db_inc >= CW'(DEBOUNCE));

   // Lowest-index row that is pulled low; descending loop lets the lowest win.
   always_comb begin
      low_idx_c = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!srows[i]) low_idx_c = 2'(i);
      end
   end

   always_comb begin
      state_nxt = state;
      cidx_nxt  = cidx;
      ridx_nxt  = ridx;
      db_nxt    = db;
      value_nxt = value;
      valid_nxt = 1'b0;
      case (state)
         SCAN: begin
            if (check_c) begin
               if (srows == 4'hF) begin
                  cidx_nxt = cidx + 2'd1;
               end else begin
                  ridx_nxt = low_idx_c;
                  db_nxt   = CW'(1);
                  if (DEBOUNCE == 1) begin
                     state_nxt = HELD;
                     value_nxt = {low_idx_c, cidx};
                     valid_nxt = 1'b1;
                  end else begin
                     state_nxt = PRESS_DB;
                  end
               end
            end
         end
         PRESS_DB: begin
            if (check_c) begin
               if (!row_up_c) begin
                  db_nxt = db_inc;
                  if (db_done_c) begin
                     state_nxt = HELD;
                     value_nxt = {ridx, cidx};
                     valid_nxt = 1'b1;
                  end
               end else begin
                  state_nxt = SCAN;
                  db_nxt    = '0;
                  cidx_nxt  = cidx + 2'd1;
               end
            end
         end
         HELD: begin
            // Only the captured row matters here; other rows are ignored.
            if (check_c && row_up_c) begin
               if (DEBOUNCE == 1) begin
                  state_nxt = SCAN;
                  db_nxt    = '0;
                  cidx_nxt  = cidx + 2'd1;
               end else begin
                  state_nxt = REL_DB;
                  db_nxt    = CW'(1);
               end
            end
         end
         REL_DB: begin
            if (check_c) begin
               if (row_up_c) begin
                  db_nxt = db_inc;
                  if (db_done_c) begin
                     state_nxt = SCAN;
                     db_nxt    = '0;
                     cidx_nxt  = cidx + 2'd1;
                  end
               end else begin
                  state_nxt = HELD;
               end
            end
         end
         default: state_nxt = SCAN;
      endcase
      held_nxt = (state_nxt == HELD) || (state_nxt == REL_DB);
      cols_nxt = ~(4'b0001 << cidx_nxt);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1 <= 4'hF;
         srows <= 4'hF;
         dwell <= '0;
         state <= SCAN;
         cidx  <= 2'd0;
         ridx  <= 2'd0;
         db    <= '0;
         cols  <= 4'b1110;
         value <= 4'h0;
         valid <= 1'b0;
         held  <= 1'b0;
      end else begin
         sync1 <= rows;
         srows <= sync1;
         dwell <= check_c ? '0 : dwell + DW'(1);
         state <= state_nxt;
         cidx  <= cidx_nxt;
         ridx  <= ridx_nxt;
         db    <= db_nxt;
         cols  <= cols_nxt;
         value <= value_nxt;
         valid <= valid_nxt;
         held  <= held_nxt;
      end
   end

endmodule
